// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: frames UART bytes into checksummed command packets.
//
// Packet: 0xA5, CMD, LEN, LEN payload bytes, CSUM where
// CSUM = (CMD + LEN + sum(payload)) mod 256. Payload bytes are written out
// to a register file as they arrive; a good checksum pulses cmd_valid.
// Every packet that completes or fails its length check is answered with
// the two-byte response 0x5A, status (0x00 ok, 0x01 bad checksum,
// 0x02 length too large). A stalled packet is abandoned silently after
// TIMEOUT_CYC idle cycles with a timeout_err pulse.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   rx_data, rx_done   received byte and its one-cycle strobe
//   tx_data, tx_en     response byte and its one-cycle FIFO write strobe
//   pl_we, pl_addr,    payload byte write strobe, 0-based index, data
//   pl_data
//   cmd_valid          one-cycle strobe for a packet with a good checksum
//   cmd_code, cmd_len  CMD and LEN bytes of the most recent packet
//   busy               high whenever a packet or response is in progress
//   timeout_err        one-cycle strobe when a packet is abandoned
module uart_cmd_ctrl #(
    parameter int unsigned MAX_LEN     = 16,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned TIMEOUT_CYC = 500_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    output logic [7:0]        tx_data,
    output logic              tx_en,
    output logic              pl_we,
    output logic [ADDR_W-1:0] pl_addr,
    output logic [7:0]        pl_data,
    output logic              cmd_valid,
    output logic [7:0]        cmd_code,
    output logic [7:0]        cmd_len,
    output logic              busy,
    output logic              timeout_err
);

    // One extra index bit so the last-byte compare never aliases on wrap.
    localparam int unsigned IDX_W = ADDR_W + 1;
    localparam int unsigned TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [7:0]      HDR_BYTE  = 8'hA5;
    localparam logic [7:0]      RESP_BYTE = 8'h5A;
    localparam logic [7:0]      ST_OK     = 8'h00;
    localparam logic [7:0]      ST_CSUM   = 8'h01;
    localparam logic [7:0]      ST_LEN    = 8'h02;
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_LEN,
        S_PAYLOAD,
        S_CSUM,
        S_RESP_HDR,
        S_RESP_STAT
    } state_t;

    state_t           state;
    logic [7:0]       acc;
    logic [IDX_W-1:0] idx;
    logic [TO_W-1:0]  to_cnt;
    logic [7:0]       status;

    // Decodes used by the state register block.
    logic in_pkt_c;
    logic to_hit_c;
    logic len_over_c;
    logic pl_last_c;

    always_comb begin
        in_pkt_c   = (state == S_CMD) || (state == S_LEN) ||
                     (state == S_PAYLOAD) || (state == S_CSUM);
        to_hit_c   = (to_cnt == TO_LAST);
        len_over_c = (32'(rx_data) > MAX_LEN);
        // cmd_len is non-zero whenever PAYLOAD is entered.
        pl_last_c  = (idx == IDX_W'(cmd_len - 8'd1));
    end

    // Packet framing FSM with registered strobes and data outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            acc         <= 8'd0;
            idx         <= '0;
            to_cnt      <= '0;
            status      <= 8'd0;
            tx_data     <= 8'd0;
            tx_en       <= 1'b0;
            pl_we       <= 1'b0;
            pl_addr     <= '0;
            pl_data     <= 8'd0;
            cmd_valid   <= 1'b0;
            cmd_code    <= 8'd0;
            cmd_len     <= 8'd0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            tx_en       <= 1'b0;
            pl_we       <= 1'b0;
            cmd_valid   <= 1'b0;
            timeout_err <= 1'b0;

            if (in_pkt_c && !rx_done && to_hit_c) begin
                // Inter-byte timeout: abandon silently, keep written payload.
                state       <= S_IDLE;
                busy        <= 1'b0;
                timeout_err <= 1'b1;
                to_cnt      <= '0;
            end else begin
                // Counter only runs while waiting on bytes of a packet.
                if (rx_done || !in_pkt_c) begin
                    to_cnt <= '0;
                end else begin
                    to_cnt <= to_cnt + TO_W'(1);
                end

                case (state)
                    S_IDLE: begin
                        if (rx_done && (rx_data == HDR_BYTE)) begin
                            state <= S_CMD;
                            busy  <= 1'b1;
                        end
                    end

                    S_CMD: begin
                        if (rx_done) begin
                            cmd_code <= rx_data;
                            acc      <= rx_data;
                            state    <= S_LEN;
                        end
                    end

                    S_LEN: begin
                        if (rx_done) begin
                            cmd_len <= rx_data;
                            acc     <= acc + rx_data;
                            if (len_over_c) begin
                                // Header byte goes out now; status follows.
                                status  <= ST_LEN;
                                tx_en   <= 1'b1;
                                tx_data <= RESP_BYTE;
                                state   <= S_RESP_HDR;
                            end else if (rx_data == 8'd0) begin
                                state <= S_CSUM;
                            end else begin
                                idx   <= '0;
                                state <= S_PAYLOAD;
                            end
                        end
                    end

                    S_PAYLOAD: begin
                        if (rx_done) begin
                            pl_we   <= 1'b1;
                            pl_addr <= idx[ADDR_W-1:0];
                            pl_data <= rx_data;
                            acc     <= acc + rx_data;
                            idx     <= idx + IDX_W'(1);
                            if (pl_last_c) begin
                                state <= S_CSUM;
                            end
                        end
                    end

                    S_CSUM: begin
                        if (rx_done) begin
                            if (rx_data == acc) begin
                                status    <= ST_OK;
                                cmd_valid <= 1'b1;
                            end else begin
                                status <= ST_CSUM;
                            end
                            tx_en   <= 1'b1;
                            tx_data <= RESP_BYTE;
                            state   <= S_RESP_HDR;
                        end
                    end

                    S_RESP_HDR: begin
                        // 0x5A is on the bus this cycle; queue the status byte.
                        tx_en   <= 1'b1;
                        tx_data <= status;
                        state   <= S_RESP_STAT;
                    end

                    S_RESP_STAT: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end

                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
